// File: rtl/phy_pkg.sv
// Shared framing constants and FSM state type for the QPSK PHY pair.
package phy_pkg;

  localparam int SOF_LEN       = 26;
  localparam int FRAME_SYMBOLS = 63;
  localparam int SPS           = 8;

  localparam logic [SOF_LEN-1:0] SOF_I = 26'h3278428;
  localparam logic [SOF_LEN-1:0] SOF_Q = 26'h272d17d;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SOF     = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_e;

  // SOF symbol k (MSB first) as a mapper code. A set SOF bit means +A,
  // while the mapper treats a set bit as -A, hence the inversion.
  function automatic logic [1:0] sof_symbol(input logic [4:0] k);
    logic [4:0] idx;
    idx = 5'(SOF_LEN - 1) - k;
    return {~SOF_I[idx], ~SOF_Q[idx]};
  endfunction

endpackage

// File: rtl/qpsk_mapper.sv
// Combinational QPSK mapper: 2-bit symbol to packed signed 12-bit I/Q pair.
module qpsk_mapper #(
  parameter int AMPLITUDE = 1024
) (
  input  logic [1:0]  sym_i,
  input  logic        zero_i,
  output logic [23:0] sample_o
);

  localparam logic [11:0] POS = 12'(AMPLITUDE);
  localparam logic [11:0] NEG = 12'(-AMPLITUDE);

  // bit1 drives I, bit0 drives Q; a set bit selects the negative level.
  always_comb begin
    sample_o = 24'h000000;
    if (!zero_i) begin
      sample_o = {(sym_i[1] ? NEG : POS), (sym_i[0] ? NEG : POS)};
    end
  end

endmodule

// File: rtl/physical_transmitter.sv
// QPSK frame transmitter: SOF preamble followed by a fixed-length payload,
// rectangular 8-sample symbols streamed to a DAC under valid/ready.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | zero samples; waits for in_valid at a symbol boundary
// ST_SOF     | 26 preamble symbols, sym_cnt 0..25
// ST_PAYLOAD | 63 payload symbols, sym_cnt 0..62; underrun sends 00
module physical_transmitter
  import phy_pkg::*;
#(
  parameter int AMPLITUDE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  input  logic        out_ready,
  output logic        underrun
);

  tx_state_e   state_q, state_d;
  logic [2:0]  sample_cnt_q, sample_cnt_d;
  logic [5:0]  sym_cnt_q, sym_cnt_d;
  logic        out_valid_q;
  logic [23:0] out_data_q, out_data_d;
  logic        underrun_q, underrun_d;

  logic        handshake;
  logic        boundary;
  logic        last_sof;
  logic        last_payload;
  logic        loads_payload;
  logic [1:0]  map_sym;
  logic        map_zero;
  logic        load;
  logic [23:0] map_sample;

  // Sample handshake, symbol boundary and whether the boundary takes input.
  always_comb begin
    handshake     = out_valid_q & out_ready;
    boundary      = handshake & (sample_cnt_q == 3'(SPS - 1));
    last_sof      = (state_q == ST_SOF) & (sym_cnt_q == 6'(SOF_LEN - 1));
    last_payload  = (state_q == ST_PAYLOAD) & (sym_cnt_q == 6'(FRAME_SYMBOLS - 1));
    loads_payload = last_sof | ((state_q == ST_PAYLOAD) & ~last_payload);
    in_ready      = loads_payload & boundary & ~rst;
  end

  // Frame sequencing; everything except the sample counter moves only at a boundary.
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    sample_cnt_d = sample_cnt_q;
    map_sym      = 2'b00;
    map_zero     = 1'b1;
    load         = 1'b0;
    underrun_d   = 1'b0;
    if (handshake) begin
      sample_cnt_d = sample_cnt_q + 3'd1;
    end
    if (boundary) begin
      load = 1'b1;
      if (loads_payload) begin
        state_d    = ST_PAYLOAD;
        sym_cnt_d  = last_sof ? 6'd0 : sym_cnt_q + 6'd1;
        map_zero   = 1'b0;
        map_sym    = in_valid ? in_data : 2'b00;
        underrun_d = ~in_valid;
      end else if (state_q == ST_SOF) begin
        sym_cnt_d = sym_cnt_q + 6'd1;
        map_zero  = 1'b0;
        map_sym   = sof_symbol(sym_cnt_q[4:0] + 5'd1);
      end else if (in_valid) begin
        // From IDLE or after the last payload symbol: start a frame at once.
        state_d   = ST_SOF;
        sym_cnt_d = 6'd0;
        map_zero  = 1'b0;
        map_sym   = sof_symbol(5'd0);
      end else begin
        state_d   = ST_IDLE;
        sym_cnt_d = 6'd0;
      end
    end
  end

  qpsk_mapper #(
    .AMPLITUDE(AMPLITUDE)
  ) u_mapper (
    .sym_i   (map_sym),
    .zero_i  (map_zero),
    .sample_o(map_sample)
  );

  assign out_data_d = load ? map_sample : out_data_q;

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= 3'd0;
      sym_cnt_q    <= 6'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 24'h000000;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      out_valid_q  <= 1'b1;
      out_data_q   <= out_data_d;
      underrun_q   <= underrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_physical_transmitter.sv
// Bench for physical_transmitter with a frame-position reference model.
module tb_physical_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'b00;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready = 1'b0;
  logic        underrun;

  physical_transmitter #(.AMPLITUDE(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam logic [11:0] POS = 12'h400;
  localparam logic [11:0] NEG = 12'hC00;
  logic [25:0] sof_i_v = 26'h3278428;
  logic [25:0] sof_q_v = 26'h272d17d;
  logic [23:0] payload_tbl [4] = '{24'h400400, 24'h400C00, 24'hC00400, 24'hC00C00};

  // Model: m_pos is the frame position of the symbol on the output
  // (-1 idle, 0..25 SOF, 26..88 payload); m_cnt counts accepted samples.
  int          m_pos = -1;
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [23:0] m_data = 24'h0;
  logic        m_underrun = 1'b0;
  logic        obs_in_ready;
  logic        exp_in_ready;

  function automatic logic [23:0] sof_value(input int k);
    return {(sof_i_v[5'(25 - k)] ? POS : NEG), (sof_q_v[5'(25 - k)] ? POS : NEG)};
  endfunction

  task automatic step(input logic r, input logic v, input logic [1:0] d, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    obs_in_ready = in_ready;
    exp_in_ready = !r && m_valid && ordy && (m_cnt == 7) && (m_pos >= 25) && (m_pos <= 87);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = 24'h0; m_cnt = 0; m_pos = -1; m_underrun = 1'b0;
    end else begin
      m_underrun = 1'b0;
      if (m_valid && ordy) begin
        if (m_cnt == 7) begin
          m_cnt = 0;
          if (m_pos == -1 || m_pos == 88) m_pos = v ? 0 : -1;
          else m_pos++;
          if (m_pos < 0) m_data = 24'h0;
          else if (m_pos < 26) m_data = sof_value(m_pos);
          else begin
            m_data = v ? payload_tbl[d] : payload_tbl[0];
            m_underrun = !v;
          end
        end else m_cnt++;
      end
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && m_pos != -1; i++) step(1'b0, 1'b0, 2'b00, 1'b1);
    repeat (3) step(1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'($urandom), 2'($urandom), 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=000000", out_data); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%0b exp=0", underrun); end
      checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", obs_in_ready); end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 2'($urandom), 1'($urandom_range(0, 3) != 0));
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL idle_out_valid got=%0b exp=1", out_valid); end
      checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL idle_out_data got=%h exp=000000", out_data); end
      checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%0b exp=0", obs_in_ready); end
    end
  endtask

  task automatic test_sof_frames();
    logic [23:0] seq[$];
    logic [1:0]  d0, d;
    int          lat, zeros;
    logic        ok;
    d0 = 2'($urandom);
    lat = 0;
    for (int i = 0; i < 20 && out_data === 24'h0; i++) begin
      step(1'b0, 1'b1, d0, 1'b1);
      lat++;
    end
    checks++; if (lat > 9 || out_data === 24'h0) begin failures++; $display("FAIL sof_latency got=%0d exp<=9", lat); end
    seq.push_back(out_data);
    while (seq.size() < 1424) begin
      d = (seq.size() < 712) ? d0 : 2'($urandom);
      step(1'b0, 1'b1, d, 1'b1);
      seq.push_back(out_data);
      checks++; if (out_data !== m_data) begin failures++; $display("FAIL frames_data got=%h exp=%h", out_data, m_data); end
      checks++; if (obs_in_ready !== exp_in_ready) begin failures++; $display("FAIL frames_in_ready got=%0b exp=%0b", obs_in_ready, exp_in_ready); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL frames_underrun got=%0b exp=0", underrun); end
    end
    checks++; if (seq[0] !== 24'h400400) begin failures++; $display("FAIL sof_sym0 got=%h exp=400400", seq[0]); end
    checks++; if (seq[8] !== 24'h400C00) begin failures++; $display("FAIL sof_sym1 got=%h exp=400c00", seq[8]); end
    for (int k = 0; k < 26; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) if (seq[8*k+j] !== sof_value(k)) ok = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL sof_symbol k=%0d got=%h exp=%h", k, seq[8*k], sof_value(k)); end
    end
    ok = 1'b1;
    for (int n = 208; n < 712; n++) if (seq[n] !== payload_tbl[d0]) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL payload_const sym=%0d exp=%h", d0, payload_tbl[d0]); end
    zeros = 0;
    foreach (seq[n]) if (seq[n] === 24'h0) zeros++;
    checks++; if (zeros != 0) begin failures++; $display("FAIL back_to_back_zeros got=%0d exp=0", zeros); end
    checks++; if (seq[712] !== 24'h400400) begin failures++; $display("FAIL frame2_sof got=%h exp=400400", seq[712]); end
    drain();
    checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL post_frame_idle got=%h exp=000000", out_data); end
  endtask

  task automatic test_stall();
    logic        ordy, was_hs;
    logic [23:0] prev;
    for (int i = 0; i < 2200; i++) begin
      ordy = (i % 23 < 18) ? 1'($urandom_range(0, 7) != 0) : 1'b0;
      prev = out_data;
      was_hs = out_valid && ordy;
      step(1'b0, 1'b1, 2'($urandom), ordy);
      checks++; if (out_data !== m_data) begin failures++; $display("FAIL stall_data got=%h exp=%h", out_data, m_data); end
      checks++; if (obs_in_ready !== exp_in_ready) begin failures++; $display("FAIL stall_in_ready got=%0b exp=%0b", obs_in_ready, exp_in_ready); end
      checks++; if (underrun !== m_underrun) begin failures++; $display("FAIL stall_underrun got=%0b exp=%0b", underrun, m_underrun); end
      if (!ordy) begin
        checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL stall_no_ready got=%0b exp=0", obs_in_ready); end
      end
      if (!was_hs) begin
        checks++; if (out_data !== prev) begin failures++; $display("FAIL stall_frozen got=%h exp=%h", out_data, prev); end
      end
    end
    drain();
  endtask

  task automatic test_underrun();
    logic v, seen_payload, p10;
    int   nz, und;
    seen_payload = 1'b0; p10 = 1'b0; nz = 0; und = 0;
    for (int i = 0; i < 900; i++) begin
      v = !((m_pos == 35) || (m_pos == 88) || (m_pos == -1 && seen_payload));
      step(1'b0, v, 2'($urandom), 1'b1);
      if (m_pos >= 26) seen_payload = 1'b1;
      if (out_data !== 24'h0) nz++;
      if (underrun === 1'b1) und++;
      checks++; if (out_data !== m_data) begin failures++; $display("FAIL underrun_data got=%h exp=%h", out_data, m_data); end
      checks++; if (underrun !== m_underrun) begin failures++; $display("FAIL underrun_pulse got=%0b exp=%0b", underrun, m_underrun); end
      checks++; if (obs_in_ready !== exp_in_ready) begin failures++; $display("FAIL underrun_in_ready got=%0b exp=%0b", obs_in_ready, exp_in_ready); end
      if (m_pos == 36 && !p10) begin
        p10 = 1'b1;
        checks++; if (out_data !== 24'h400400) begin failures++; $display("FAIL underrun_sym10 got=%h exp=400400", out_data); end
      end
    end
    checks++; if (!p10) begin failures++; $display("FAIL underrun_reached got=0 exp=1"); end
    checks++; if (und != 1) begin failures++; $display("FAIL underrun_count got=%0d exp=1", und); end
    checks++; if (nz != 712) begin failures++; $display("FAIL underrun_frame_len got=%0d exp=712", nz); end
    drain();
  endtask

  task automatic test_reset_midframe();
    int n;
    for (int i = 0; i < 1000 && m_pos != 56; i++) begin
      step(1'b0, 1'b1, 2'($urandom), 1'b1);
      checks++; if (out_data !== m_data) begin failures++; $display("FAIL midframe_data got=%h exp=%h", out_data, m_data); end
    end
    checks++; if (m_pos != 56) begin failures++; $display("FAIL midframe_reach got=%0d exp=56", m_pos); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'($urandom), 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL midrst_out_data got=%h exp=000000", out_data); end
      checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=0", obs_in_ready); end
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 2'($urandom), 1'b1);
      checks++; if (out_valid !== 1'b1 || out_data !== 24'h0) begin
        failures++; $display("FAIL post_rst_idle got=%0b/%h exp=1/000000", out_valid, out_data);
      end
    end
    n = 0;
    for (int i = 0; i < 20 && out_data === 24'h0; i++) begin step(1'b0, 1'b1, 2'($urandom), 1'b1); n++; end
    checks++; if (out_data !== 24'h400400) begin failures++; $display("FAIL restart_sof0 got=%h exp=400400", out_data); end
    for (int i = 0; i < 26 * 8; i++) begin
      step(1'b0, 1'b1, 2'($urandom), 1'b1);
      checks++; if (out_data !== m_data) begin failures++; $display("FAIL restart_data got=%h exp=%h", out_data, m_data); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sof_frames();
    test_stall();
    test_underrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
